// File: rtl/fpmul_pipe_if.sv
// fpmul_pipe_if: operand/result valid-ready bus for fpmul_pipe.
interface fpmul_pipe_if #(
  parameter int EXP_W = 4,
  parameter int MAN_W = 8
) ();
  localparam int W = 1 + EXP_W + MAN_W;
  logic i_valid, o_ready, o_valid, i_ready, o_nan, o_ovf, o_unf;
  logic [W-1:0] i_data1, i_data2, o_mul;
  modport slave (
    input  i_valid, i_data1, i_data2, i_ready,
    output o_ready, o_valid, o_mul, o_nan, o_ovf, o_unf
  );
  modport master (
    output i_valid, i_data1, i_data2, i_ready,
    input  o_ready, o_valid, o_mul, o_nan, o_ovf, o_unf
  );
endinterface

// File: rtl/fpmul_pipe.sv
// fpmul_pipe: 3-stage pipelined floating-point multiplier with valid/ready flow control.
// Define FPMUL_PIPE_ROUND_EN for round-half-up; the default build truncates.
module fpmul_pipe #(
  parameter int EXP_W = 4,
  parameter int MAN_W = 8
) (
  input logic         i_clock,
  input logic         i_reset_n,
  fpmul_pipe_if.slave bus
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int M  = MAN_W;
  localparam int XW = EXP_W + 2;
  localparam logic signed [XW-1:0] BIAS = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);
  localparam logic [W-1:0] NAN = {1'b1, {EXP_W{1'b1}}, 1'b1, {(M-1){1'b0}}};

  logic w_en;
  logic [EXP_W-1:0] w_e1, w_e2;
  logic [M-1:0] w_m1, w_m2;
  logic w_z1, w_z2, w_i1, w_i2, w_n1, w_n2;
  logic [2*M-1:0] w_p;
  logic w_unused;
  logic r_v1, r_s1, r_nan1, r_zero1, r_inf1;
  logic signed [XW-1:0] r_e1;
  logic [M+1:0] r_p1;
  logic w_norm, w_cy;
  logic [M-1:0] w_mn, w_mr, w_m;
  logic signed [XW-1:0] w_e;
  logic r_v2, r_s2, r_nan2, r_zero2, r_inf2;
  logic signed [XW-1:0] r_e2;
  logic [M-1:0] r_m2;
  logic w_le0, w_ge, w_zero, w_inf;
  logic [W-1:0] w_mul;
  logic r_v3, r_nan, r_ovf, r_unf;
  logic [W-1:0] r_mul;

  assign w_en        = ~r_v3 | bus.i_ready;
  assign bus.o_ready = w_en;
  assign bus.o_valid = r_v3;
  assign bus.o_mul   = r_mul;
  assign bus.o_nan   = r_nan;
  assign bus.o_ovf   = r_ovf;
  assign bus.o_unf   = r_unf;

  assign w_e1 = bus.i_data1[W-2:M];
  assign w_e2 = bus.i_data2[W-2:M];
  assign w_m1 = bus.i_data1[M-1:0];
  assign w_m2 = bus.i_data2[M-1:0];
  assign w_z1 = ~|w_e1;
  assign w_z2 = ~|w_e2;
  assign w_i1 = &w_e1 & ~|w_m1;
  assign w_i2 = &w_e2 & ~|w_m2;
  assign w_n1 = &w_e1 & |w_m1;
  assign w_n2 = &w_e2 & |w_m2;
  assign w_p  = (2*M)'(w_m1) * (2*M)'(w_m2);
  // only P[2M-1:M-2] can reach the result mantissa or round bit
  assign w_unused = ^w_p[M-3:0];

  assign w_norm = r_p1[M+1];
  assign w_mn   = w_norm ? r_p1[M+1:2] : r_p1[M:1];
`ifdef FPMUL_PIPE_ROUND_EN
  assign {w_cy, w_mr} = {1'b0, w_mn} + (M+1)'(w_norm ? r_p1[1] : r_p1[0]);
`else
  logic w_unused_rb;
  assign w_unused_rb  = r_p1[0];
  assign {w_cy, w_mr} = {1'b0, w_mn};
`endif
  assign w_m = w_cy ? {1'b1, {(M-1){1'b0}}} : w_mr;
  assign w_e = r_e1 + XW'(w_norm) + XW'(w_cy);

  assign w_le0  = r_e2[XW-1] | ~|r_e2;
  assign w_ge   = r_e2 >= EMAX;
  assign w_zero = r_zero2 | w_le0;
  assign w_inf  = r_inf2 | w_ge;
  assign w_mul  = r_nan2 ? NAN :
                  w_zero ? {r_s2, {(W-1){1'b0}}} :
                  w_inf  ? {r_s2, {EXP_W{1'b1}}, {M{1'b0}}} :
                           {r_s2, r_e2[EXP_W-1:0], r_m2};

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_v1  <= 1'b0;
      r_v2  <= 1'b0;
      r_v3  <= 1'b0;
      r_mul <= '0;
      r_nan <= 1'b0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (w_en) begin
      r_v1    <= bus.i_valid;
      r_s1    <= bus.i_data1[W-1] ^ bus.i_data2[W-1];
      r_nan1  <= w_n1 | w_n2 | (w_i1 & w_z2) | (w_i2 & w_z1);
      r_zero1 <= w_z1 | w_z2;
      r_inf1  <= w_i1 | w_i2;
      r_e1    <= XW'(w_e1) + XW'(w_e2) - BIAS;
      r_p1    <= w_p[2*M-1:M-2];
      r_v2    <= r_v1;
      r_s2    <= r_s1;
      r_nan2  <= r_nan1;
      r_zero2 <= r_zero1;
      r_inf2  <= r_inf1;
      r_e2    <= w_e;
      r_m2    <= w_m;
      r_v3    <= r_v2;
      if (r_v2) begin
        r_mul <= w_mul;
        r_nan <= r_nan2;
        r_unf <= ~r_nan2 & ~r_zero2 & w_le0;
        r_ovf <= ~r_nan2 & ~w_zero & ~r_inf2 & w_ge;
      end
    end
  end
endmodule

// File: tb/tb_fpmul_pipe.sv
// tb_fpmul_pipe: randomized scoreboard bench for fpmul_pipe against an integer reference model.
module tb_fpmul_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fpmul_pipe_if #(.EXP_W(4), .MAN_W(8)) bus ();
  fpmul_pipe #(.EXP_W(4), .MAN_W(8)) dut (.i_clock(clk), .i_reset_n(rst_n), .bus(bus));

  typedef struct { logic [15:0] v; int cyc; } exp_t;
  exp_t q[$];
  int total = 0, bad = 0, cyc = 0;
  bit lat_exact = 0, done = 0, stop = 0, pend_rst = 0, stall_prev = 0;
  logic [15:0] prev_out;

  always @(posedge clk) cyc++;

  // expected {nan, ovf, unf, product}
  function automatic logic [15:0] model(logic [12:0] a, logic [12:0] b);
    int e1, e2, m1, m2, p, e, mant, rb;
    bit s, z1, z2, i1, i2, n1, n2;
    e1 = a[11:8]; e2 = b[11:8]; m1 = a[7:0]; m2 = b[7:0];
    s = a[12] ^ b[12];
    z1 = e1 == 0; z2 = e2 == 0;
    i1 = e1 == 15 && m1 == 0; i2 = e2 == 15 && m2 == 0;
    n1 = e1 == 15 && m1 != 0; n2 = e2 == 15 && m2 != 0;
    if (n1 || n2 || (i1 && z2) || (i2 && z1)) return {3'b100, 13'h1F80};
    p = m1 * m2;
    e = e1 + e2 - 7;
    if (p >= 32768) begin mant = p / 256; rb = (p / 128) % 2; e++; end
    else begin mant = p / 128; rb = (p / 64) % 2; end
`ifdef FPMUL_PIPE_ROUND_EN
    mant = mant + rb;
    if (mant == 256) begin mant = 128; e++; end
`else
    rb = 0;
`endif
    if (z1 || z2) return {3'b000, s, 12'h000};
    if (e <= 0) return {3'b001, s, 12'h000};
    if (i1 || i2) return {3'b000, s, 12'hF00};
    if (e >= 15) return {3'b010, s, 12'hF00};
    return {3'b000, s, e[3:0], mant[7:0]};
  endfunction

  function automatic logic [12:0] gen();
    int sel;
    logic [3:0] e;
    logic [7:0] m;
    sel = $urandom_range(0, 9);
    e = 4'($urandom_range(0, 15));
    m = {1'b1, 7'($urandom)};
    if (sel == 0) m = 8'h00;
    if (sel == 1) e = 4'h0;
    if (sel == 2) e = 4'hF;
    if (sel == 3) m = 8'($urandom);
    return {1'($urandom), e, m};
  endfunction

  task automatic send(input logic [12:0] a, input logic [12:0] b);
    bit acc;
    int n;
    n = 0;
    bus.i_valid = 1'b1; bus.i_data1 = a; bus.i_data2 = b;
    do begin
      @(negedge clk);
      acc = bus.o_ready && rst_n;
      if (acc) q.push_back('{model(a, b), cyc});
      @(posedge clk); #2;
      if (++n > 1000) begin
        $display("FAIL accept_timeout: got no accept want accept within 1000 cycles");
        $fatal(1);
      end
    end while (!acc);
    bus.i_valid = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    logic [15:0] out;
    exp_t e;
    out = {bus.o_nan, bus.o_ovf, bus.o_unf, bus.o_mul};
    if (!rst_n) begin
      q.delete();
      pend_rst = 1;
      stall_prev = 0;
    end else begin
      if (pend_rst) begin
        chk("reset_out", out, 16'h0000);
        chk("reset_valid", 16'(bus.o_valid), 16'h0000);
        chk("reset_ready", 16'(bus.o_ready), 16'h0001);
        pend_rst = 0;
      end
      if (stall_prev) chk("stall_hold", out, prev_out);
      chk("ready_rule", 16'(bus.o_ready), 16'(!bus.o_valid || bus.i_ready));
      if (bus.o_valid && bus.i_ready) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_result: got %h want none", out);
        end else begin
          e = q.pop_front();
          chk("result", out, e.v);
          if (lat_exact) chk("latency", 16'(cyc - e.cyc), 16'd3);
        end
      end
      stall_prev = bus.o_valid && !bus.i_ready;
      prev_out = out;
    end
    if (done) begin
      chk("drained", 16'(q.size()), 16'h0000);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  logic [12:0] dir_a [9] = '{13'h0780, 13'h17C0, 13'h07C1, 13'h0E80, 13'h0180, 13'h0F00, 13'h0F00, 13'h0F01, 13'h07B5};
  logic [12:0] dir_b [9] = '{13'h0780, 13'h07C0, 13'h07C1, 13'h0E80, 13'h0180, 13'h0000, 13'h0780, 13'h0780, 13'h07B5};

  initial begin
    bus.i_valid = 1'b0; bus.i_ready = 1'b1;
    bus.i_data1 = '0; bus.i_data2 = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #2;
    lat_exact = 1;
    for (int i = 0; i < 9; i++) begin
      send(dir_a[i], dir_b[i]);
      @(posedge clk); #2;
    end
    repeat (5) @(posedge clk); #2;
    lat_exact = 0;
    fork
      for (int i = 0; i < 6; i++) send(gen(), gen());
      begin
        repeat (3) @(posedge clk);
        #2 bus.i_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2 bus.i_ready = 1'b1;
      end
    join
    repeat (8) @(posedge clk); #2;
    for (int i = 0; i < 3; i++) send(gen(), gen());
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (8) @(posedge clk); #2;
    send(13'h0780, 13'h0780);
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
          send(gen(), gen());
        end
        stop = 1;
      end
      begin
        while (!stop) begin
          @(posedge clk); #2;
          bus.i_ready = $urandom_range(0, 3) != 0;
        end
        bus.i_ready = 1'b1;
      end
    join
    for (int k = 0; k < 200 && q.size() != 0; k++) @(posedge clk);
    #2 done = 1;
  end
endmodule
